// File: rtl/draw_scheduler.sv
// draw_scheduler: round-robin arbiter that hands the draw engine to one of three
// requesters and holds its command for a fixed draw window.
module draw_scheduler #(
  parameter int DRAW_CYCLES = 2401,
  parameter int CNT_W = 12
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       pause,
  input  logic [2:0] req,
  input  logic [4:0] cmd0,
  input  logic [4:0] cmd1,
  input  logic [4:0] cmd2,
  output logic [2:0] grant,
  output logic [2:0] done,
  output logic       busy,
  output logic       item,
  output logic       erase,
  output logic [2:0] position
);
  typedef enum logic [1:0] {IDLE, DRAW, SKIP} state_t;
  state_t state;
  logic [1:0] ptr, win, p1, p2, sel;
  logic [CNT_W-1:0] cnt;
  logic [4:0] wcmd;
  logic fin;
  always_comb begin
    p1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
    sel = req[ptr] ? ptr : req[p1] ? p1 : p2;
    wcmd = sel == 2'd0 ? cmd0 : sel == 2'd1 ? cmd1 : cmd2;
    fin = state == SKIP || (state == DRAW && cnt == CNT_W'(DRAW_CYCLES - 1));
  end
  // Illegal positions never reach the engine, so its inputs keep the last legal command.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      win <= '0;
      cnt <= '0;
      grant <= '0;
      done <= '0;
      busy <= 1'b0;
      {erase, item, position} <= '0;
    end else begin
      grant <= '0;
      done <= '0;
      if (state == IDLE) begin
        if (!pause && |req) begin
          win <= sel;
          grant <= 3'b001 << sel;
          cnt <= '0;
          busy <= 1'b1;
          if (wcmd[2:0] <= 3'd5) begin
            {erase, item, position} <= wcmd;
            state <= DRAW;
          end else
            state <= SKIP;
        end
      end else if (fin) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 3'b001 << win;
        ptr <= win == 2'd2 ? 2'd0 : win + 2'd1;
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed stimulus against a countdown-based model of the
// scheduler's request/grant/done behaviour.
module tb_draw_scheduler;
  localparam int D = 2401;
  logic CLOCK_50 = 0, reset_n = 0, pause = 0;
  logic [2:0] req = 0;
  logic [4:0] cmd0 = 0, cmd1 = 0, cmd2 = 0;
  logic [2:0] grant, done, position;
  logic busy, item, erase;

  draw_scheduler dut (.CLOCK_50(CLOCK_50), .reset_n(reset_n), .pause(pause), .req(req),
    .cmd0(cmd0), .cmd1(cmd1), .cmd2(cmd2), .grant(grant), .done(done), .busy(busy),
    .item(item), .erase(erase), .position(position));

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0, n_err = 0, g2_seen = 0;
  bit chk_en = 0;
  int left = 0, owner = 0, mptr = 0;
  logic [2:0] e_grant = 0, e_done = 0, e_pos = 0;
  logic e_busy = 0, e_item = 0, e_erase = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a window is a count of busy cycles left; done fires as it reaches zero.
  always @(posedge CLOCK_50) begin
    logic [4:0] c;
    if (!reset_n) begin
      left = 0; mptr = 0; owner = 0;
      {e_grant, e_done, e_busy, e_item, e_erase, e_pos} = '0;
    end else begin
      e_grant = 0; e_done = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          e_done = 3'b001 << owner;
          mptr = (owner + 1) % 3;
        end
      end else if (!pause && req != 0) begin
        for (int k = 2; k >= 0; k--) if (req[(mptr + k) % 3]) owner = (mptr + k) % 3;
        c = owner == 0 ? cmd0 : owner == 1 ? cmd1 : cmd2;
        e_grant = 3'b001 << owner;
        if (c[2:0] <= 5) begin
          {e_erase, e_item, e_pos} = c;
          left = D;
        end else left = 1;
      end
      e_busy = left > 0;
    end
    chk_en = 1;
  end

  always @(negedge CLOCK_50) if (chk_en) begin
    if (grant[2]) g2_seen++;
    chk("grant", grant, e_grant);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("engine", {erase, item, position}, {e_erase, e_item, e_pos});
  end

  task automatic run_window(output int n);
    n = 0;
    for (int i = 0; i < 3000 && done == 0; i++) begin
      if (busy) n++;
      @(negedge CLOCK_50);
    end
    chk("window_timeout", done != 0, 1);
  endtask

  initial begin
    int n, k, cyc, t[4];
    logic [2:0] g[4];
    repeat (3) @(negedge CLOCK_50);
    chk("rst_out", {grant, done, busy, erase, item, position}, 0);
    reset_n = 1;
    // Single request from requester 0
    cmd0 = 5'b11011; req = 3'b001;
    @(negedge CLOCK_50);
    chk("t1_grant", grant, 3'b001);
    chk("t1_engine", {erase, item, position}, 5'b11011);
    req = 0;
    run_window(n);
    chk("t1_busy_len", n, D);
    chk("t1_done", done, 3'b001);
    chk("t1_busy_off", busy, 0);
    @(negedge CLOCK_50);
    chk("t1_done_pulse", done, 0);
    // Round robin with all requests held, from a fresh pointer
    reset_n = 0; @(negedge CLOCK_50); reset_n = 1;
    cmd0 = 5'b00001; cmd1 = 5'b01010; cmd2 = 5'b10100; req = 3'b111;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 12000) begin
      @(negedge CLOCK_50); cyc++;
      if (grant != 0) begin
        g[k] = grant; t[k] = cyc; k++;
        if (k == 4) req = 0;
      end
    end
    chk("rr_count", k, 4);
    chk("rr_g0", g[0], 3'b001);
    chk("rr_g1", g[1], 3'b010);
    chk("rr_g2", g[2], 3'b100);
    chk("rr_g3", g[3], 3'b001);
    for (int i = 1; i < 4; i++) chk("rr_interval", t[i] - t[i-1], D + 1);
    run_window(n);
    chk("rr_done", done, 3'b001);
    // Illegal position takes the skip path
    cmd1 = 5'b01111; req = 3'b010;
    @(negedge CLOCK_50);
    chk("skip_grant", grant, 3'b010);
    chk("skip_busy", busy, 1);
    chk("skip_engine", {erase, item, position}, 5'b00001);
    req = 0;
    @(negedge CLOCK_50);
    chk("skip_done", done, 3'b010);
    chk("skip_busy_off", busy, 0);
    chk("skip_engine2", {erase, item, position}, 5'b00001);
    // Pause blocks grants until released
    pause = 1; req = 3'b100;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      chk("pause_nogrant", grant, 0);
    end
    pause = 0;
    @(negedge CLOCK_50);
    chk("pause_grant", grant, 3'b100);
    chk("pause_engine", {erase, item, position}, 5'b10100);
    req = 0;
    run_window(n);
    chk("pause_len", n, D);
    // Reset mid-window
    cmd0 = 5'b01010; req = 3'b001;
    @(negedge CLOCK_50);
    chk("mid_grant", grant, 3'b001);
    req = 0;
    repeat (1000) @(negedge CLOCK_50);
    reset_n = 0;
    @(negedge CLOCK_50);
    chk("mid_rst_out", {grant, done, busy, erase, item, position}, 0);
    reset_n = 1; req = 3'b011;
    @(negedge CLOCK_50);
    chk("post_rst_grant", grant, 3'b001);
    req = 0;
    // Requester 2 drops its request before the running window ends
    repeat (100) @(negedge CLOCK_50);
    req = 3'b100;
    repeat (500) @(negedge CLOCK_50);
    req = 0;
    n = g2_seen;
    run_window(k);
    repeat (20) @(negedge CLOCK_50);
    chk("dropped_req", g2_seen - n, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
